// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial add/subtract sequencer built around one full_adder
//
// A start pulse in IDLE latches two WIDTH-bit operands. The single full adder is
// then stepped one bit per clock, LSB first, with a registered carry. After
// WIDTH steps the result and flags are published and done pulses for one cycle.
//
// Optional feature macro: SERIAL_ADDER_SUB_EN
//   defined   : sub=1 computes a-b as a + ~b + 1
//   undefined : sub is ignored and the block always computes a+b
//
// Ports:
//   clk       in   1      rising-edge clock
//   rst_n     in   1      asynchronous active-low reset
//   start     in   1      operation request, sampled only in IDLE
//   sub       in   1      1 = a-b, 0 = a+b (only with SERIAL_ADDER_SUB_EN)
//   a, b      in   WIDTH  operands, sampled with start
//   busy      out  1      high in RUN and DONE
//   done      out  1      one-cycle pulse when the result becomes valid
//   sum       out  WIDTH  result, held until the next accepted start
//   cout      out  1      final carry out of the MSB (sub: 1 = no borrow)
//   overflow  out  1      signed overflow (carry into MSB ^ carry out of MSB)

module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);
    assign o_s    = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [CW-1:0]    r_count;
    logic             w_sub_eff;
    logic             w_s;
    logic             w_co;
    logic             w_load;
    logic             w_last;

`ifdef SERIAL_ADDER_SUB_EN
    assign w_sub_eff = sub;
`else
    logic w_unused_sub;
    assign w_unused_sub = sub;
    assign w_sub_eff    = 1'b0;
`endif

    assign w_load = (r_state == IDLE) && start;
    assign w_last = (r_state == RUN) && (r_count == LAST);

    full_adder u_fa (
        .i_a    (r_a[0]),
        .i_b    (r_b[0]),
        .i_cin  (r_carry),
        .o_s    (w_s),
        .o_cout (w_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        busy   = r_state != IDLE;
        done   = r_state == DONE;
        if (w_load)                w_next = RUN;
        else if (w_last)           w_next = DONE;
        else if (r_state == DONE)  w_next = IDLE;
    end

    // Subtraction is a + ~b + 1: invert b at load time and seed the carry.
    // On the final step r_carry is the carry into the MSB, which gives overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_carry  <= 1'b0;
            r_count  <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else if (w_load) begin
            r_a     <= a;
            r_b     <= w_sub_eff ? ~b : b;
            r_carry <= w_sub_eff;
            r_count <= '0;
        end else if (r_state == RUN) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_res   <= {w_s, r_res[WIDTH-1:1]};
            r_carry <= w_co;
            if (w_last) begin
                sum      <= {w_s, r_res[WIDTH-1:1]};
                cout     <= w_co;
                overflow <= r_carry ^ w_co;
            end else begin
                r_count <= r_count + CW'(1);
            end
        end
    end
endmodule
